// File: rtl/blackparrot_fpga_host_write_from_axil_if.sv
// AXI4-Lite write channel bundle (AW, W, B) between host interconnect and CSR write slave.
interface blackparrot_fpga_host_write_from_axil_if #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned STRB_W = DATA_W / 8;

   logic [ADDR_W-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [2:0]        awprot;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;

   modport master (
      output awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
      input  awready, wready, bresp, bvalid
   );

   modport slave (
      input  awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
      output awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/blackparrot_fpga_host_write_from_axil.sv
// AXI4-Lite write slave: buffers AW/W, decodes the address against a CSR table and
// forwards the write data onto the matching ready/valid FIFO lane, one write at a time.
module blackparrot_fpga_host_write_from_axil #(
   parameter int unsigned S_AXIL_ADDR_WIDTH = 64,
   parameter int unsigned S_AXIL_DATA_WIDTH = 32,
   parameter int unsigned CSR_ELS_P         = 1,
   parameter logic [CSR_ELS_P-1:0][S_AXIL_ADDR_WIDTH-1:0] csr_addr_p = '0
) (
   input  logic                                          s_axil_aclk,
   input  logic                                          s_axil_aresetn,
   blackparrot_fpga_host_write_from_axil_if.slave        s_axil,
   output logic [CSR_ELS_P-1:0]                          fifo_v_o,
   input  logic [CSR_ELS_P-1:0]                          fifo_ready_i,
   output logic [CSR_ELS_P-1:0][S_AXIL_DATA_WIDTH-1:0]   fifo_data_o
);
   localparam int unsigned AW = S_AXIL_ADDR_WIDTH;
   localparam int unsigned DW = S_AXIL_DATA_WIDTH;

   typedef enum logic [1:0] {ST_IDLE, ST_DISPATCH, ST_RESP} state_e;

   state_e state_q, state_n;

   // two-entry AW buffer
   logic [1:0][AW-1:0] aw_mem_q;
   logic               aw_wptr_q, aw_rptr_q;
   logic [1:0]         aw_cnt_q, aw_cnt_n;
   logic               aw_ready_q;
   logic               aw_push_c;
   logic [AW-1:0]      aw_head_c;

   // two-entry W buffer
   logic [1:0][DW-1:0] w_mem_q;
   logic               w_wptr_q, w_rptr_q;
   logic [1:0]         w_cnt_q, w_cnt_n;
   logic               w_ready_q;
   logic               w_push_c;
   logic [DW-1:0]      w_head_c;

   logic                 heads_v_c;
   logic                 pop_c;
   logic                 hit_c;
   logic [CSR_ELS_P-1:0] grant_c;
   logic                 fire_c;

   logic [CSR_ELS_P-1:0] fifo_v_q, fifo_v_n;
   logic [DW-1:0]        data_q, data_n;
   logic                 bvalid_q, bvalid_n;

   logic unused_c;

   assign unused_c = ^{s_axil.awprot, s_axil.wstrb};

   assign aw_push_c = s_axil.awvalid & aw_ready_q;
   assign w_push_c  = s_axil.wvalid & w_ready_q;
   assign aw_head_c = aw_mem_q[aw_rptr_q];
   assign w_head_c  = w_mem_q[w_rptr_q];
   assign heads_v_c = (aw_cnt_q != 2'd0) && (w_cnt_q != 2'd0);
   assign aw_cnt_n  = aw_cnt_q + 2'(aw_push_c) - 2'(pop_c);
   assign w_cnt_n   = w_cnt_q + 2'(w_push_c) - 2'(pop_c);
   assign fire_c    = |(fifo_v_q & fifo_ready_i);

   assign s_axil.awready = aw_ready_q;
   assign s_axil.wready  = w_ready_q;
   assign s_axil.bvalid  = bvalid_q;
   assign s_axil.bresp   = 2'b00;
   assign fifo_v_o       = fifo_v_q;
   assign fifo_data_o    = {CSR_ELS_P{data_q}};

   // AW buffer storage, pointers and registered not-full flag
   always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
      if (!s_axil_aresetn) begin
         aw_mem_q   <= '0;
         aw_wptr_q  <= 1'b0;
         aw_rptr_q  <= 1'b0;
         aw_cnt_q   <= 2'd0;
         aw_ready_q <= 1'b0;
      end else begin
         if (aw_push_c) begin
            aw_mem_q[aw_wptr_q] <= s_axil.awaddr;
            aw_wptr_q           <= ~aw_wptr_q;
         end
         if (pop_c) aw_rptr_q <= ~aw_rptr_q;
         aw_cnt_q   <= aw_cnt_n;
         aw_ready_q <= (aw_cnt_n != 2'd2);
      end
   end

   // W buffer storage, pointers and registered not-full flag
   always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
      if (!s_axil_aresetn) begin
         w_mem_q   <= '0;
         w_wptr_q  <= 1'b0;
         w_rptr_q  <= 1'b0;
         w_cnt_q   <= 2'd0;
         w_ready_q <= 1'b0;
      end else begin
         if (w_push_c) begin
            w_mem_q[w_wptr_q] <= s_axil.wdata;
            w_wptr_q          <= ~w_wptr_q;
         end
         if (pop_c) w_rptr_q <= ~w_rptr_q;
         w_cnt_q   <= w_cnt_n;
         w_ready_q <= (w_cnt_n != 2'd2);
      end
   end

   // fixed-priority address decode, lowest matching index wins
   always_comb begin
      grant_c = '0;
      hit_c   = 1'b0;
      for (int i = 0; i < int'(CSR_ELS_P); i++) begin
         if (!hit_c && (aw_head_c == csr_addr_p[i])) begin
            grant_c[i] = 1'b1;
            hit_c      = 1'b1;
         end
      end
   end

   // state register
   always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
      if (!s_axil_aresetn) state_q <= ST_IDLE;
      else                 state_q <= state_n;
   end

   // next state and buffer pop
   always_comb begin
      state_n = state_q;
      pop_c   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (heads_v_c) begin
               pop_c   = ~hit_c;
               state_n = hit_c ? ST_DISPATCH : ST_RESP;
            end
         end
         ST_DISPATCH: begin
            if (fire_c) begin
               pop_c   = 1'b1;
               state_n = ST_RESP;
            end
         end
         ST_RESP: begin
            if (s_axil.bready) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // next values of the registered FIFO and B outputs
   always_comb begin
      fifo_v_n = fifo_v_q;
      data_n   = data_q;
      bvalid_n = bvalid_q;
      case (state_q)
         ST_IDLE: begin
            if (heads_v_c && hit_c) begin
               fifo_v_n = grant_c;
               data_n   = w_head_c;
            end else if (heads_v_c) begin
               bvalid_n = 1'b1;
            end
         end
         ST_DISPATCH: begin
            if (fire_c) begin
               fifo_v_n = '0;
               bvalid_n = 1'b1;
            end
         end
         ST_RESP: begin
            if (s_axil.bready) bvalid_n = 1'b0;
         end
         default: begin
            fifo_v_n = '0;
            bvalid_n = 1'b0;
         end
      endcase
   end

   // output registers
   always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
      if (!s_axil_aresetn) begin
         fifo_v_q <= '0;
         data_q   <= '0;
         bvalid_q <= 1'b0;
      end else begin
         fifo_v_q <= fifo_v_n;
         data_q   <= data_n;
         bvalid_q <= bvalid_n;
      end
   end
endmodule
